// File: rtl/mem_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the byte-serial memory controller:
//   - MEM-stage load/store aluop codes and the aluop bus width
//   - FSM state encoding and transfer-owner encoding
//   - decode_access(): aluop -> {valid, is_store, nbytes}
// ----------------------------------------------------------------------------
package mem_ctrl_pkg;

  localparam int ALU_OP_BUS_W = 8;

  typedef logic [ALU_OP_BUS_W-1:0] aluop_t;

  // MEM-stage load/store operation codes
  localparam aluop_t EXE_LB_OP  = 8'hE0;
  localparam aluop_t EXE_LH_OP  = 8'hE1;
  localparam aluop_t EXE_LW_OP  = 8'hE3;
  localparam aluop_t EXE_LBU_OP = 8'hE4;
  localparam aluop_t EXE_LHU_OP = 8'hE5;
  localparam aluop_t EXE_SB_OP  = 8'hE8;
  localparam aluop_t EXE_SH_OP  = 8'hE9;
  localparam aluop_t EXE_SW_OP  = 8'hEB;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  typedef struct packed {
    logic       valid;     // op is a load or a store
    logic       is_store;
    logic [2:0] nbytes;    // 1, 2 or 4
  } access_t;

  // Map a MEM-stage aluop to its access class; anything else is idle.
  function automatic access_t decode_access(input aluop_t aluop);
    access_t acc;
    acc = '0;
    case (aluop)
      EXE_LB_OP, EXE_LBU_OP: acc = '{valid: 1'b1, is_store: 1'b0, nbytes: 3'd1};
      EXE_LH_OP, EXE_LHU_OP: acc = '{valid: 1'b1, is_store: 1'b0, nbytes: 3'd2};
      EXE_LW_OP:             acc = '{valid: 1'b1, is_store: 1'b0, nbytes: 3'd4};
      EXE_SB_OP:             acc = '{valid: 1'b1, is_store: 1'b1, nbytes: 3'd1};
      EXE_SH_OP:             acc = '{valid: 1'b1, is_store: 1'b1, nbytes: 3'd2};
      EXE_SW_OP:             acc = '{valid: 1'b1, is_store: 1'b1, nbytes: 3'd4};
      default:               acc = '0;
    endcase
    return acc;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// ----------------------------------------------------------------------------
// mem_ctrl_if
// Bundles the fetch port, the load/store port and the byte-wide RAM port of
// the memory controller.
//   slave  : controller view (requests and ram_din in; done/data/RAM drive out)
//   master : environment view (pipeline stages and RAM)
// ----------------------------------------------------------------------------
interface mem_ctrl_if #(
  parameter int ADDR_W  = 32,
  parameter int ALUOP_W = 8
);

  // instruction fetch
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_inst;

  // MEM-stage load/store
  logic [ALUOP_W-1:0] ls_aluop;
  logic [ADDR_W-1:0]  ls_addr;
  logic [31:0]        ls_wdata;
  logic               ls_done;
  logic [31:0]        ls_rdata;

  // single-port byte RAM
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  modport slave (
    input  if_req, if_addr, ls_aluop, ls_addr, ls_wdata, ram_din,
    output if_done, if_inst, ls_done, ls_rdata, ram_addr, ram_wr, ram_dout
  );

  modport master (
    output if_req, if_addr, ls_aluop, ls_addr, ls_wdata, ram_din,
    input  if_done, if_inst, ls_done, ls_rdata, ram_addr, ram_wr, ram_dout
  );

endinterface

// File: rtl/mem_ctrl_arb.sv
// ----------------------------------------------------------------------------
// mem_ctrl_arb
// Combinational fixed-priority picker between load/store and fetch.
// Load/store wins so a stalled MEM stage is always released first.
//   idle     in  controller can accept a new transfer
//   if_req   in  fetch pending
//   ls_valid in  load/store pending
//   grant_ls out start a load/store this cycle
//   grant_if out start a fetch this cycle
// ----------------------------------------------------------------------------
module mem_ctrl_arb (
  input  logic idle,
  input  logic if_req,
  input  logic ls_valid,
  output logic grant_ls,
  output logic grant_if
);

  assign grant_ls = idle & ls_valid;
  assign grant_if = idle & if_req & ~ls_valid;

endmodule

// File: rtl/mem_ctrl.sv
// ----------------------------------------------------------------------------
// mem_ctrl
// Byte-serial controller sharing one 8-bit single-port RAM between
// instruction fetch and MEM-stage loads/stores. Each access is split into
// 1, 2 or 4 byte transfers at base+0..base+n-1 (32-bit wrap), read data is
// assembled little-endian, and the owner gets a one-cycle done pulse.
//   clk, rst  clock, asynchronous active-high reset
//   bus       mem_ctrl_if.slave: if_* fetch port, ls_* load/store port,
//             ram_* byte RAM port (ram_din valid the cycle after ram_addr)
// ----------------------------------------------------------------------------
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int ALUOP_W = 8
) (
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
);

  // FSM and transfer context
  state_t            state,  state_d;
  owner_t            owner,  owner_d;
  logic [2:0]        cnt,    cnt_d;     // cycles spent in READ/WRITE
  logic [2:0]        nbytes, nbytes_d;
  logic [ADDR_W-1:0] base,   base_d;
  logic [31:0]       wbuf,   wbuf_d;    // store bytes still to send, LSB next
  logic [31:0]       rbuf,   rbuf_d;    // read bytes assembled so far

  // registered outputs
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_wr_q,   ram_wr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic [31:0]       if_inst_q,  if_inst_d;
  logic [31:0]       ls_rdata_q, ls_rdata_d;

  logic [ALUOP_W-1:0] ls_op;
  access_t            ls_acc;
  logic               grant_ls, grant_if;
  logic [2:0]         cnt_nxt;
  logic [1:0]         cap_idx;
  logic [31:0]        captured;

  assign ls_op  = bus.ls_aluop;
  assign ls_acc = decode_access(ALU_OP_BUS_W'(ls_op));

  mem_ctrl_arb u_arb (
    .idle     (state == ST_IDLE),
    .if_req   (bus.if_req),
    .ls_valid (ls_acc.valid),
    .grant_ls (grant_ls),
    .grant_if (grant_if)
  );

  // In READ cycle cnt, ram_din carries byte cnt-1 (address issued one cycle
  // earlier), so it lands in lane cnt-1 of the assembly buffer.
  assign cnt_nxt  = cnt + 3'd1;
  assign cap_idx  = 2'(cnt - 3'd1);
  assign captured = rbuf | (32'(bus.ram_din) << {cap_idx, 3'b000});

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; an unassigned path in always_comb would infer a latch.
  always_comb begin
    state_d    = state;
    owner_d    = owner;
    cnt_d      = cnt;
    nbytes_d   = nbytes;
    base_d     = base;
    wbuf_d     = wbuf;
    rbuf_d     = rbuf;
    ram_addr_d = ram_addr_q;
    ram_wr_d   = 1'b0;
    ram_dout_d = ram_dout_q;
    if_inst_d  = if_inst_q;
    ls_rdata_d = ls_rdata_q;

    unique case (state)
      ST_IDLE: begin
        // Op class is carried by the next state (READ vs WRITE).
        cnt_d  = 3'd0;
        rbuf_d = '0;
        if (grant_ls) begin
          owner_d    = OWN_LS;
          base_d     = bus.ls_addr;
          nbytes_d   = ls_acc.nbytes;
          ram_addr_d = bus.ls_addr;
          if (ls_acc.is_store) begin
            state_d    = ST_WRITE;
            ram_wr_d   = 1'b1;
            ram_dout_d = bus.ls_wdata[7:0];
            wbuf_d     = bus.ls_wdata >> 8;
          end else begin
            state_d = ST_READ;
          end
        end else if (grant_if) begin
          owner_d    = OWN_IF;
          base_d     = bus.if_addr;
          nbytes_d   = 3'd4;
          ram_addr_d = bus.if_addr;
          state_d    = ST_READ;
        end
      end

      ST_READ: begin
        cnt_d = cnt_nxt;
        if (cnt_nxt < nbytes) begin
          ram_addr_d = base + ADDR_W'(cnt_nxt);
        end
        if (cnt != 3'd0) begin
          rbuf_d = captured;
        end
        if (cnt == nbytes) begin
          state_d = ST_DONE;
          if (owner == OWN_LS) ls_rdata_d = captured;
          else                 if_inst_d  = captured;
        end
      end

      ST_WRITE: begin
        cnt_d = cnt_nxt;
        if (cnt_nxt < nbytes) begin
          ram_wr_d   = 1'b1;
          ram_addr_d = base + ADDR_W'(cnt_nxt);
          ram_dout_d = wbuf[7:0];
          wbuf_d     = wbuf >> 8;
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // Requests are still visible here; ignoring them prevents a relaunch.
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_IF;
      cnt        <= '0;
      nbytes     <= '0;
      base       <= '0;
      wbuf       <= '0;
      rbuf       <= '0;
      ram_addr_q <= '0;
      ram_wr_q   <= 1'b0;
      ram_dout_q <= '0;
      if_inst_q  <= '0;
      ls_rdata_q <= '0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      cnt        <= cnt_d;
      nbytes     <= nbytes_d;
      base       <= base_d;
      wbuf       <= wbuf_d;
      rbuf       <= rbuf_d;
      ram_addr_q <= ram_addr_d;
      ram_wr_q   <= ram_wr_d;
      ram_dout_q <= ram_dout_d;
      if_inst_q  <= if_inst_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_wr   = ram_wr_q;
  assign bus.ram_dout = ram_dout_q;
  assign bus.if_inst  = if_inst_q;
  assign bus.ls_rdata = ls_rdata_q;
  assign bus.if_done  = (state == ST_DONE) && (owner == OWN_IF);
  assign bus.ls_done  = (state == ST_DONE) && (owner == OWN_LS);

endmodule
